width_128to24: RTL

Serializer that accepts 128-bit words from an upstream valid/ready source and emits a stream of 24-bit words to a downstream valid/ready sink, MSB-first with no gaps or padding between input words. It is the transmit-side counterpart of the 24→128 packer: three 128-bit inputs (384 bits) yield exactly sixteen 24-bit outputs, and feeding the output back into the packer reproduces the original 128-bit words. Residue bits are carried across input-word boundaries in an internal left-aligned buffer.

---
 rtl/width_128to24_if.sv | 32 +++
 rtl/width_128to24.sv | 65 ++++++
 2 files changed

// File: rtl/width_128to24_if.sv
// rtl/width_128to24_if.sv - stream bundle for the 128-to-24 serializer (flush member with W128TO24_FLUSH_EN)
interface width_128to24_if;
  logic         valid_in;
  logic [127:0] data_in;
  logic         ready_in;
  logic         valid_out;
  logic [23:0]  data_out;
  logic         ready_out;
`ifdef W128TO24_FLUSH_EN
  logic         flush;

  modport master (
    output valid_in, data_in, ready_out, flush,
    input  ready_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_out, flush,
    output ready_in, valid_out, data_out
  );
`else
  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out
  );
`endif
endinterface

// File: rtl/width_128to24.sv
// rtl/width_128to24.sv - 128-bit to 24-bit MSB-first serializer; optional residue flush with W128TO24_FLUSH_EN
module width_128to24 (
  input  logic           clk,
  input  logic           rst_n,
  width_128to24_if.slave bus
);

  localparam logic [7:0] OUT_W = 8'd24;
  localparam logic [7:0] IN_W  = 8'd128;

  // Left-aligned residue: valid bits live at buf_q[151 -: fill_q], everything below is zero.
  logic [151:0] buf_q;
  logic [151:0] buf_d;
  logic [151:0] buf_after;
  logic [151:0] in_aligned;
  logic [7:0]   fill_q;
  logic [7:0]   fill_d;
  logic [7:0]   fill_after;
  logic         pop;
  logic         accept;
  logic         flush_pad;

  assign bus.valid_out = (fill_q >= OUT_W);
  assign bus.data_out  = buf_q[151:128];

`ifdef W128TO24_FLUSH_EN
  // A flush cycle blocks intake so the padded residue is emitted on its own.
  assign bus.ready_in = (fill_q <= OUT_W) && !bus.flush;
  assign flush_pad    = bus.flush && (fill_q != 8'd0) && (fill_q < OUT_W);
`else
  assign bus.ready_in = (fill_q <= OUT_W);
  assign flush_pad    = 1'b0;
`endif

  assign pop    = bus.valid_out && bus.ready_out;
  assign accept = bus.valid_in && bus.ready_in;

  // Next state: pop first, then append the new word just below the surviving residue.
  always_comb begin
    fill_after = pop ? (fill_q - OUT_W) : fill_q;
    buf_after  = pop ? {buf_q[127:0], 24'd0} : buf_q;
    in_aligned = {bus.data_in, 24'd0} >> fill_after;
    buf_d      = buf_after;
    fill_d     = fill_after;
    if (accept) begin
      buf_d  = buf_after | in_aligned;
      fill_d = fill_after + IN_W;
    end else if (flush_pad) begin
      // Low bits are already zero, so claiming a full slice pads the residue.
      fill_d = OUT_W;
    end
  end

  // Buffer and fill registers; reset discards any residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

endmodule
